// File: rtl/mem_stage_ctrl.sv
// Memory-stage request controller: turns latched EX/MEM load/store intent into a
// held data-memory request, captures load data, stalls the pipeline, flags errors and sequences halt.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              exm_dREN_i,
  input  logic              exm_dWEN_i,
  input  logic [DATA_W-1:0] exm_addr_i,
  input  logic [DATA_W-1:0] exm_store_i,
  input  logic              exm_halt_i,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] load_o,
  output logic              load_valid_o,
  output logic              stall_o,
  output logic              mem_err_o,
  output logic              halt_o
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = TIMEOUT[WDOG_W-1:0];

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

  state_t            state, state_nxt;
  logic              armed;
  logic [WDOG_W-1:0] wdog;
  logic              req;
  logic              aligned;

  assign req     = armed & (exm_dREN_i | exm_dWEN_i);
  assign aligned = (exm_addr_i[1:0] == 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req)             state_nxt = aligned ? ACCESS : DONE;
        else if (exm_halt_i) state_nxt = HALTED;
      end
      ACCESS:  if (dhit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      armed     <= 1'b1;
      wdog      <= '0;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      load_o    <= '0;
      mem_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && aligned) begin
            dmemaddr  <= exm_addr_i;
            dmemstore <= exm_store_i;
            dmemWEN   <= exm_dWEN_i;
            dmemREN   <= exm_dREN_i & ~exm_dWEN_i;
            wdog      <= '0;
            if (exm_dREN_i && exm_dWEN_i) mem_err_o <= 1'b1;
          end else if (req) begin
            // Misaligned: no bus access; the entry is consumed like a finished one.
            mem_err_o <= 1'b1;
            armed     <= 1'b0;
          end
        end
        ACCESS: begin
          if (dhit) begin
            if (dmemREN) load_o <= dmemload;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            wdog    <= '0;
            armed   <= 1'b0;
          end else if (wdog == WDOG_MAX) begin
            mem_err_o <= 1'b1;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: ;
      endcase
      // A pipeline advance brings a fresh EX/MEM entry, so issuing is allowed again.
      if (ihit && state != ACCESS) armed <= 1'b1;
    end
  end

  assign load_valid_o = (state == DONE);
  assign halt_o       = (state == HALTED);
  assign stall_o      = (state == ACCESS) | ((state == IDLE) & req);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: each task drives one scenario and compares
// outputs against hand-computed values, sampled 1ns after the rising edge.
module tb_mem_stage_ctrl;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 255;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              exm_dREN_i, exm_dWEN_i, exm_halt_i, ihit, dhit;
  logic [DATA_W-1:0] exm_addr_i, exm_store_i, dmemload;
  logic              dmemREN, dmemWEN, load_valid_o, stall_o, mem_err_o, halt_o;
  logic [DATA_W-1:0] dmemaddr, dmemstore, load_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .exm_dREN_i(exm_dREN_i), .exm_dWEN_i(exm_dWEN_i),
    .exm_addr_i(exm_addr_i), .exm_store_i(exm_store_i), .exm_halt_i(exm_halt_i),
    .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_o(load_o), .load_valid_o(load_valid_o), .stall_o(stall_o),
    .mem_err_o(mem_err_o), .halt_o(halt_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    exm_dREN_i = 0; exm_dWEN_i = 0; exm_halt_i = 0; ihit = 0; dhit = 0;
    exm_addr_i = '0; exm_store_i = '0; dmemload = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic rearm();
    exm_dREN_i = 0; exm_dWEN_i = 0; ihit = 1;
    tick();
    ihit = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin n_err++; $display("FAIL reset_en: got ren=%b wen=%b want 0 0", dmemREN, dmemWEN); end
    n_cmp++; if (load_o !== 32'h0 || dmemaddr !== 32'h0) begin n_err++; $display("FAIL reset_data: got load=%h addr=%h want 0 0", load_o, dmemaddr); end
    n_cmp++; if ({load_valid_o, stall_o, mem_err_o, halt_o} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {load_valid_o, stall_o, mem_err_o, halt_o}); end
  endtask

  task automatic test_load();
    int pulses = 0;
    exm_dREN_i = 1; exm_addr_i = 32'h40;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL load_stall_idle: got %b want 1", stall_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h40 || stall_o !== 1'b1) begin n_err++; $display("FAIL load_hold_c%0d: got ren=%b wen=%b addr=%h stall=%b want 1 0 40 1", i, dmemREN, dmemWEN, dmemaddr, stall_o); end
      if (i == 2) begin dhit = 1; dmemload = 32'hDEADBEEF; end
      tick();
    end
    dhit = 0; dmemload = 32'h0;
    n_cmp++; if (load_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_data: got %h want deadbeef", load_o); end
    n_cmp++; if (dmemREN !== 1'b0 || stall_o !== 1'b0) begin n_err++; $display("FAIL load_done: got ren=%b stall=%b want 0 0", dmemREN, stall_o); end
    for (int i = 0; i < 4; i++) begin
      if (load_valid_o === 1'b1) pulses++;
      n_cmp++; if (dmemREN !== 1'b0) begin n_err++; $display("FAIL load_no_reissue_c%0d: got ren=%b want 0", i, dmemREN); end
      tick();
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL load_valid_pulses: got %0d want 1", pulses); end
    rearm();
  endtask

  task automatic test_store();
    exm_dWEN_i = 1; exm_addr_i = 32'h44; exm_store_i = 32'h12345678;
    tick();
    exm_store_i = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== 32'h44 || dmemstore !== 32'h12345678) begin n_err++; $display("FAIL store_hold_c%0d: got wen=%b ren=%b addr=%h data=%h want 1 0 44 12345678", i, dmemWEN, dmemREN, dmemaddr, dmemstore); end
      if (i == 1) begin dhit = 1; dmemload = 32'h0BADF00D; end
      tick();
    end
    dhit = 0;
    n_cmp++; if (load_o !== 32'hDEADBEEF || load_valid_o !== 1'b1 || dmemWEN !== 1'b0) begin n_err++; $display("FAIL store_done: got load=%h valid=%b wen=%b want deadbeef 1 0", load_o, load_valid_o, dmemWEN); end
    tick(); tick();
    n_cmp++; if (dmemWEN !== 1'b0 || stall_o !== 1'b0) begin n_err++; $display("FAIL store_no_reissue: got wen=%b stall=%b want 0 0", dmemWEN, stall_o); end
    rearm();
  endtask

  task automatic test_misaligned();
    int pulses = 0;
    exm_dREN_i = 1; exm_addr_i = 32'h42;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load_valid_o === 1'b1) pulses++;
      n_cmp++; if (dmemREN !== 1'b0) begin n_err++; $display("FAIL mis_ren_c%0d: got %b want 0", i, dmemREN); end
    end
    n_cmp++; if (mem_err_o !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", mem_err_o); end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL mis_valid_pulses: got %0d want 1", pulses); end
    rearm();
  endtask

  task automatic test_timeout();
    apply_reset();
    exm_dREN_i = 1; exm_addr_i = 32'h80;
    tick();
    for (int i = 0; i < int'(TIMEOUT); i++) tick();
    n_cmp++; if (mem_err_o !== 1'b0 || dmemREN !== 1'b1) begin n_err++; $display("FAIL tmo_before: got err=%b ren=%b want 0 1", mem_err_o, dmemREN); end
    tick();
    n_cmp++; if (mem_err_o !== 1'b1 || dmemREN !== 1'b1 || stall_o !== 1'b1) begin n_err++; $display("FAIL tmo_at: got err=%b ren=%b stall=%b want 1 1 1", mem_err_o, dmemREN, stall_o); end
    tick(); tick();
    n_cmp++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h80) begin n_err++; $display("FAIL tmo_keep_req: got ren=%b addr=%h want 1 80", dmemREN, dmemaddr); end
    dhit = 1; dmemload = 32'hCAFEF00D;
    tick();
    dhit = 0;
    n_cmp++; if (load_o !== 32'hCAFEF00D || load_valid_o !== 1'b1 || dmemREN !== 1'b0 || mem_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_complete: got load=%h valid=%b ren=%b err=%b want cafef00d 1 0 1", load_o, load_valid_o, dmemREN, mem_err_o); end
    tick();
    rearm();
  endtask

  task automatic test_reset_mid_access();
    exm_dREN_i = 1; exm_addr_i = 32'h100;
    tick(); tick();
    n_cmp++; if (dmemREN !== 1'b1) begin n_err++; $display("FAIL rst_pre: got ren=%b want 1", dmemREN); end
    #2;
    clear_inputs();
    nRST = 1'b0;
    #1;
    n_cmp++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || stall_o !== 1'b0 || mem_err_o !== 1'b0) begin n_err++; $display("FAIL rst_async: got ren=%b wen=%b stall=%b err=%b want 0 0 0 0", dmemREN, dmemWEN, stall_o, mem_err_o); end
    tick();
    nRST = 1'b1;
    dhit = 1; dmemload = 32'h11111111;
    tick();
    dhit = 0;
    n_cmp++; if (load_o !== 32'h0 || load_valid_o !== 1'b0) begin n_err++; $display("FAIL idle_dhit_ignored: got load=%h valid=%b want 0 0", load_o, load_valid_o); end
    exm_dREN_i = 1; exm_addr_i = 32'h100;
    #1;
    n_cmp++; if (stall_o !== 1'b1 || dmemREN !== 1'b0) begin n_err++; $display("FAIL rst_idle_armed: got stall=%b ren=%b want 1 0", stall_o, dmemREN); end
    exm_dREN_i = 0;
  endtask

  task automatic test_conflict();
    apply_reset();
    exm_dREN_i = 1; exm_dWEN_i = 1; exm_addr_i = 32'h50; exm_store_i = 32'h0F0F0F0F;
    tick();
    n_cmp++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || mem_err_o !== 1'b1 || dmemstore !== 32'h0F0F0F0F) begin n_err++; $display("FAIL conflict_issue: got wen=%b ren=%b err=%b data=%h want 1 0 1 0f0f0f0f", dmemWEN, dmemREN, mem_err_o, dmemstore); end
    dhit = 1; ihit = 1; dmemload = 32'h55555555;
    tick();
    dhit = 0; ihit = 0;
    n_cmp++; if (load_o !== 32'h0 || load_valid_o !== 1'b1 || dmemWEN !== 1'b0) begin n_err++; $display("FAIL conflict_done: got load=%h valid=%b wen=%b want 0 1 0", load_o, load_valid_o, dmemWEN); end
    tick(); tick();
    n_cmp++; if (dmemWEN !== 1'b0 || dmemREN !== 1'b0 || stall_o !== 1'b0) begin n_err++; $display("FAIL conflict_ihit_ignored: got wen=%b ren=%b stall=%b want 0 0 0", dmemWEN, dmemREN, stall_o); end
  endtask

  task automatic test_halt();
    apply_reset();
    exm_dWEN_i = 1; exm_halt_i = 1; exm_addr_i = 32'h48; exm_store_i = 32'hA5A5A5A5;
    tick();
    n_cmp++; if (dmemWEN !== 1'b1 || halt_o !== 1'b0 || dmemstore !== 32'hA5A5A5A5) begin n_err++; $display("FAIL halt_store_issue: got wen=%b halt=%b data=%h want 1 0 a5a5a5a5", dmemWEN, halt_o, dmemstore); end
    dhit = 1;
    tick();
    dhit = 0;
    n_cmp++; if (load_valid_o !== 1'b1 || halt_o !== 1'b0 || dmemWEN !== 1'b0) begin n_err++; $display("FAIL halt_store_done: got valid=%b halt=%b wen=%b want 1 0 0", load_valid_o, halt_o, dmemWEN); end
    tick(); tick();
    n_cmp++; if (halt_o !== 1'b1 || stall_o !== 1'b0) begin n_err++; $display("FAIL halt_taken: got halt=%b stall=%b want 1 0", halt_o, stall_o); end
    ihit = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (halt_o !== 1'b1 || dmemWEN !== 1'b0 || stall_o !== 1'b0) begin n_err++; $display("FAIL halt_terminal_c%0d: got halt=%b wen=%b stall=%b want 1 0 0", i, halt_o, dmemWEN, stall_o); end
    end
    ihit = 0;
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b1;
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_conflict();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
